// File: rtl/data_point_nd_buffer.sv
// data_point_nd_buffer
//
// N-dimensional signed data-point buffer for the graphing path. Points arrive
// on a valid/ready stream and are held in a DEPTH-entry circular buffer. The
// oldest point is presented first-word-fall-through to the render stage. A
// running per-axis bounding box (min/max) of every accepted point is kept for
// auto-scaling.
//
// Parameters
//   DIMS      axes per point (1..8)
//   WIDTH     signed bits per axis
//   DEPTH     buffer entries, power of two, >= 2
//   OVERWRITE 0: backpressure when full; 1: accept when full, drop oldest
//
// Ports
//   clk, rst           clock and synchronous active-high reset
//   clear              synchronous flush of buffer, overflow and bounds
//   in_valid/in_ready  producer handshake; in_point axis k at [k*WIDTH +: WIDTH]
//   out_valid/out_ready consumer handshake; out_point is the oldest point
//   count/full/empty   occupancy status
//   overflow           sticky: an overwrite discard happened since reset/clear
//   bounds_valid       at least one point accepted since reset/clear
//   min_bound/max_bound per-axis signed min/max of accepted points
module data_point_nd_buffer #(
  parameter int DIMS      = 2,
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 64,
  parameter int OVERWRITE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIMS*WIDTH-1:0]     in_point,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIMS*WIDTH-1:0]     out_point,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  output logic                      bounds_valid,
  output logic [DIMS*WIDTH-1:0]     min_bound,
  output logic [DIMS*WIDTH-1:0]     max_bound
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = DIMS * WIDTH;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          wr_en;
  logic          rd_en;
  logic          drop;
  logic          flush;

  function automatic logic [PW-1:0] axis_min(input logic [PW-1:0] a,
                                             input logic [PW-1:0] b);
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;
    axis_min = a;
    for (int k = 0; k < DIMS; k++) begin
      x = a[k*WIDTH +: WIDTH];
      y = b[k*WIDTH +: WIDTH];
      if (y < x) axis_min[k*WIDTH +: WIDTH] = y;
    end
  endfunction

  function automatic logic [PW-1:0] axis_max(input logic [PW-1:0] a,
                                             input logic [PW-1:0] b);
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;
    axis_max = a;
    for (int k = 0; k < DIMS; k++) begin
      x = a[k*WIDTH +: WIDTH];
      y = b[k*WIDTH +: WIDTH];
      if (y > x) axis_max[k*WIDTH +: WIDTH] = y;
    end
  endfunction

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign out_valid = !empty;
  assign out_point = mem[rd_ptr];
  // Ready depends only on registered occupancy (and rst), never on in_valid.
  assign in_ready  = !rst && ((OVERWRITE != 0) || !full);

  assign flush = rst || clear;
  assign wr_en = in_valid && in_ready;
  assign rd_en = out_valid && out_ready;
  // A write into a full buffer (overwrite mode only) pushes the head out.
  assign drop  = wr_en && full;

  // Control state: pointers, occupancy, sticky flags and bounding box
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      overflow     <= 1'b0;
      bounds_valid <= 1'b0;
      min_bound    <= '0;
      max_bound    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      // Read and discard both consume the head; they never stack.
      if (rd_en || drop) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en && !full) begin
        count_q <= count_q + 1'b1;
      end else if (rd_en && !wr_en) begin
        count_q <= count_q - 1'b1;
      end
      if (drop && !rd_en) overflow <= 1'b1;
      if (wr_en) begin
        bounds_valid <= 1'b1;
        if (!bounds_valid) begin
          min_bound <= in_point;
          max_bound <= in_point;
        end else begin
          min_bound <= axis_min(min_bound, in_point);
          max_bound <= axis_max(max_bound, in_point);
        end
      end
    end
  end

  // Storage array: not reset; clear drops a same-cycle write
  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem[wr_ptr] <= in_point;
  end

endmodule

// File: tb/tb_data_point_nd_buffer.sv
module tb_data_point_nd_buffer;

  localparam int DIMS  = 2;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int PW    = DIMS * WIDTH;

  typedef logic [PW-1:0] pt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  pt_t  in_point = '0;

  logic [1:0] in_ready_v;
  logic [1:0] out_valid_v;
  logic [1:0] full_v;
  logic [1:0] empty_v;
  logic [1:0] ovf_v;
  logic [1:0] bv_v;
  logic [2:0] count_v [2];
  pt_t        out_point_v [2];
  pt_t        min_v [2];
  pt_t        max_v [2];

  // Reference model: point queues, history of accepted points, expected reads
  pt_t mq   [2][$];
  pt_t acc  [2][$];
  pt_t expq [2][$];
  bit  m_ovf [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_point_nd_buffer #(.DIMS(DIMS), .WIDTH(WIDTH), .DEPTH(DEPTH), .OVERWRITE(0)) dut0 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_v[0]), .in_point(in_point),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_point(out_point_v[0]),
    .count(count_v[0]), .full(full_v[0]), .empty(empty_v[0]),
    .overflow(ovf_v[0]), .bounds_valid(bv_v[0]),
    .min_bound(min_v[0]), .max_bound(max_v[0])
  );

  data_point_nd_buffer #(.DIMS(DIMS), .WIDTH(WIDTH), .DEPTH(DEPTH), .OVERWRITE(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_v[1]), .in_point(in_point),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_point(out_point_v[1]),
    .count(count_v[1]), .full(full_v[1]), .empty(empty_v[1]),
    .overflow(ovf_v[1]), .bounds_valid(bv_v[1]),
    .min_bound(min_v[1]), .max_bound(max_v[1])
  );

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, i, act, exp, $time);
    end
  endtask

  function automatic pt_t mk(input int a, input int b);
    return {16'(b), 16'(a)};
  endfunction

  // Bounding box as min/max over the whole history of accepted points.
  function automatic pt_t bound(input int i, input bit want_max);
    pt_t r;
    logic signed [WIDTH-1:0] v;
    logic signed [WIDTH-1:0] best;
    r = '0;
    for (int k = 0; k < DIMS; k++) begin
      best = '0;
      for (int j = 0; j < acc[i].size(); j++) begin
        v = acc[i][j][k*WIDTH +: WIDTH];
        if (j == 0 || (want_max ? (v > best) : (v < best))) best = v;
      end
      r[k*WIDTH +: WIDTH] = best;
    end
    return r;
  endfunction

  task automatic check_state();
    int sz;
    for (int i = 0; i < 2; i++) begin
      sz = mq[i].size();
      chk("count",        i, 32'(count_v[i]),     32'(sz));
      chk("full",         i, 32'(full_v[i]),      32'(sz == DEPTH));
      chk("empty",        i, 32'(empty_v[i]),     32'(sz == 0));
      chk("out_valid",    i, 32'(out_valid_v[i]), 32'(sz > 0));
      chk("overflow",     i, 32'(ovf_v[i]),       32'(m_ovf[i]));
      chk("bounds_valid", i, 32'(bv_v[i]),        32'(acc[i].size() > 0));
      chk("min_bound",    i, min_v[i],            bound(i, 1'b0));
      chk("max_bound",    i, max_v[i],            bound(i, 1'b1));
      if (sz > 0) chk("out_point", i, out_point_v[i], mq[i][0]);
    end
  endtask

  // One clock of stimulus; the model steps with the same inputs.
  task automatic cyc(input logic iv, input pt_t p, input logic ordy,
                     input logic clr, input logic r);
    int sz;
    bit rdy, wr, rd;
    @(negedge clk);
    check_state();
    in_valid  = iv;
    in_point  = p;
    out_ready = ordy;
    clear     = clr;
    rst       = r;
    #1;
    for (int i = 0; i < 2; i++) begin
      sz  = mq[i].size();
      rdy = !r && ((i == 1) || (sz < DEPTH));
      chk("in_ready", i, 32'(in_ready_v[i]), 32'(rdy));
      if (r || clr) begin
        mq[i].delete();
        acc[i].delete();
        m_ovf[i] = 1'b0;
      end else begin
        wr = iv && rdy;
        rd = ordy && (sz > 0);
        if (rd) expq[i].push_back(mq[i].pop_front());
        if (wr) begin
          if (mq[i].size() == DEPTH) begin
            void'(mq[i].pop_front());
            m_ovf[i] = 1'b1;
          end
          mq[i].push_back(p);
          acc[i].push_back(p);
        end
      end
    end
  endtask

  // Monitor: just before each rising edge, every consumer handshake pops one
  // expected point from the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      for (int i = 0; i < 2; i++) begin
        if (out_valid_v[i] && out_ready && !clear && !rst) begin
          if (expq[i].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL read_unexpected inst%0d: got %h expected no read", i, out_point_v[i]);
          end else begin
            chk("read_data", i, out_point_v[i], expq[i].pop_front());
          end
        end
      end
    end
  end

  initial begin
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Three points held, bounds and head
    cyc(1'b1, mk(3, -5), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, mk(10, 2), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, mk(-7, 8), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    // Fill and offer a fifth, then read all
    cyc(1'b1, mk(4, 4), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, mk(5, -20), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Axis-0 sequence 1..5 into a 4-deep buffer
    for (int v = 1; v <= 5; v++) cyc(1'b1, mk(v, 0), 1'b0, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Streaming at count 2 across pointer wrap
    cyc(1'b1, mk(50, 1), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, mk(51, 2), 1'b0, 1'b0, 1'b0);
    for (int v = 0; v < 10; v++) cyc(1'b1, mk(100 + v, -v), 1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // clear with simultaneous write and read at count 3
    cyc(1'b1, mk(-1, -1), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, mk(7, 7), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, mk(8, -8), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, mk(9, 9), 1'b1, 1'b1, 1'b0);
    cyc(1'b1, mk(-2, 6), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // rst pulse mid-stream
    cyc(1'b1, mk(300, -300), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, mk(1, 2), 1'b1, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with occasional clear/reset
    for (int n = 0; n < 400; n++) begin
      cyc(1'b1 && ($urandom_range(0, 3) != 0), pt_t'($urandom),
          (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0),
          $urandom_range(0, 40) == 0, $urandom_range(0, 80) == 0);
    end

    repeat (6) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #6;
    for (int i = 0; i < 2; i++) chk("reads_pending", i, 32'(expq[i].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_point_nd_buffer.md
# data_point_nd_buffer

Parametrised N-dimensional data-point buffer for the Graphing path; successor to the fixed 2-D point holder. Accepts signed points over a valid/ready stream and stores them in a circular buffer of DEPTH entries. Presents the oldest point first-word-fall-through to the plotting/render stage. Also maintains a running per-axis bounding box (min/max) for auto-scaling.

## Interface
- DIMS, 2, number of axes per point (1..8)
- WIDTH, 16, signed bits per axis
- DEPTH, 64, buffer entries; power of two, >= 2
- OVERWRITE, 0, 0 = backpressure when full; 1 = accept when full, discard oldest
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- clear  input  1  synchronous flush of buffer and bounds
- in_valid  input  1  producer has a point
- in_ready  output  1  buffer accepts a point this cycle
- in_point  input  DIMS*WIDTH  axis k at bits [k*WIDTH +: WIDTH], two's complement
- out_valid  output  1  head point available
- out_ready  input  1  consumer takes head point
- out_point  output  DIMS*WIDTH  oldest stored point, same packing
- count  output  $clog2(DEPTH)+1  stored points, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overflow  output  1  sticky; an OVERWRITE discard occurred since reset/clear
- bounds_valid  output  1  at least one point accepted since reset/clear
- min_bound  output  DIMS*WIDTH  per-axis signed minimum of accepted points
- max_bound  output  DIMS*WIDTH  per-axis signed maximum of accepted points

## Operation
- Storage: register array DEPTH x (DIMS*WIDTH), write pointer wr_ptr, read pointer rd_ptr, both $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0 naturally; count held separately so full and empty are unambiguous.
- Write accept: in_valid && in_ready. in_ready = !full when OVERWRITE=0; constant 1 when OVERWRITE=1 (0 during rst).
- Read accept: out_valid && out_ready. out_valid = !empty. out_point = mem[rd_ptr] (FWFT); value is don't-care when empty.
- Count: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
- Full with OVERWRITE=0: no write possible. A simultaneous read frees a slot only for the next cycle.
- Full with OVERWRITE=1 and write accepted: store at wr_ptr and advance both pointers; count stays DEPTH. Set overflow, unless a read is accepted in the same cycle. In that case the read consumes the head, rd_ptr advances once, count stays DEPTH, and overflow is unchanged.
- Empty with write: no read possible (out_valid=0); point visible at out_point the next cycle.
- Bounds: on each accepted write, each axis is compared signed. The first accepted point after reset/clear loads min=max=point and sets bounds_valid. Reads and overwrite discards never shrink bounds; they cover all points accepted since the last reset/clear.
- clear: pointers and count go to 0, overflow=0, bounds_valid=0, min/max=0. It takes priority over any write or read in the same cycle; those transfers are dropped. in_ready is unaffected by clear.
- rst: same effect as clear, plus in_ready=0 while rst is asserted.
- Memory contents are not reset.

## Timing
- Reset values: in_ready=0 during rst, then !full (=1) or 1 after; out_valid=0, count=0, full=0, empty=1, overflow=0, bounds_valid=0, min_bound=0, max_bound=0, out_point don't-care.
- Write-to-read latency: a point accepted at edge N is on out_point with out_valid=1 after edge N (usable at edge N+1).
- count, full, empty, overflow, bounds_valid and min/max are registered and update at the edge that accepts the transfer.
- in_ready and out_valid are combinational from registered count only, with no path from in_valid/out_ready. Sustained throughput: one write and one read per cycle.
- rst or clear asserted mid-stream: the state is empty from the following cycle. No partial transfer survives.

## Test plan
- DIMS=2, WIDTH=16, DEPTH=4. Write (3,-5),(10,2),(-7,8) and hold out_ready=0 -> count=3; min=(-7,-5), max=(10,8); out_point=(3,-5).
- Fill 4 points with OVERWRITE=0, then offer a 5th -> in_ready=0, full=1, 5th not stored. Read all -> order preserved, empty=1; bounds unchanged.
- OVERWRITE=1: write 1,2,3,4,5 (axis0) -> count=4, overflow=1, read sequence 2,3,4,5.
- Simultaneous write and read at count=2 for 10 cycles with incrementing data -> count stays 2, strict FIFO order across pointer wrap.
- clear asserted together with in_valid and out_ready at count=3 -> next cycle count=0, empty=1, bounds_valid=0, overflow=0. The next write loads min=max=that point.
- rst pulse mid-stream -> all outputs at reset values the following cycle; in_ready=0 while rst=1.
